data_ram_ctrl: RTL and testbench



---
 rtl/dram_pkg.sv | 21 ++
 rtl/dram_load_align.sv | 30 +++
 rtl/data_ram_ctrl.sv | 136 +++++++++++++
 tb/tb_data_ram_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states
// and the zero word used for cleared memory and empty responses.
package dram_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [31:0] ZERO_WORD = '0;

endpackage

// File: rtl/dram_load_align.sv
// Load-path lane selection: shifts the addressed byte/half down to bit 0
// and sign- or zero-extends it to 32 bits.
module dram_load_align (
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);
  import dram_pkg::*;

  logic [31:0] shifted;
  size_e       sz;

  assign sz      = size_e'(size);
  assign shifted = word >> {addr_lo, 3'b000};

  always_comb begin
    data = ZERO_WORD;
    case (sz)
      SIZE_BYTE: data = uns ? {24'h0, shifted[7:0]}
                            : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: data = uns ? {16'h0, shifted[15:0]}
                            : {{16{shifted[15]}}, shifted[15:0]};
      SIZE_WORD: data = word;
      default:   data = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/data_ram_ctrl.sv
// MEM-stage data RAM: valid/ready request/response with one outstanding access,
// byte/half/word lanes, error reporting, configurable read latency, zero-init.
module data_ram_ctrl #(
  parameter int DEPTH        = 32,
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter bit INIT_ZERO    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);
  import dram_pkg::*;

  localparam int AW     = $clog2(DEPTH);
  localparam int WIDX_W = ADDR_W - 2;

  state_e      state, state_n;
  logic [AW-1:0] init_ptr;
  logic [1:0]  lat_cnt;
  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;
  logic        err_q;

  size_e       sz;
  logic        accept, acc_err, misalign, range_err;
  logic [AW-1:0] idx;
  logic [3:0]  lane_en;
  logic [31:0] wdata_rep;
  logic [31:0] ld_data;

  assign sz        = size_e'(req_size);
  assign idx       = req_addr[AW+1:2];
  assign range_err = req_addr[ADDR_W-1:2] >= WIDX_W'(DEPTH);
  assign acc_err   = misalign | range_err;
  assign req_ready = (state == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign resp_valid = (state == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    misalign  = 1'b0;
    lane_en   = 4'b0000;
    wdata_rep = req_wdata;
    case (sz)
      SIZE_BYTE: begin
        lane_en   = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        misalign  = req_addr[0];
        lane_en   = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      SIZE_WORD: begin
        misalign = |req_addr[1:0];
        lane_en  = 4'b1111;
      end
      default: misalign = 1'b1;
    endcase
  end

  // Async array read at acceptance; the result is parked in rdata_q until the
  // latency counter expires, which matches a READ_LATENCY-deep pipeline since
  // nothing else can touch the array while the access is outstanding.
  dram_load_align u_align (
    .word    (mem[idx]),
    .addr_lo (req_addr[1:0]),
    .size    (req_size),
    .uns     (req_unsigned),
    .data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[init_ptr] <= ZERO_WORD;
      end else if (accept && req_we && !acc_err) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (lane_en[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_INIT: if (init_ptr == AW'(DEPTH - 1)) state_n = ST_IDLE;
      ST_IDLE: begin
        if (accept) begin
          if (acc_err || req_we || READ_LATENCY == 1) state_n = ST_RESP;
          else                                        state_n = ST_WAIT;
        end
      end
      ST_WAIT: if (lat_cnt == 2'd1) state_n = ST_RESP;
      ST_RESP: if (resp_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT_ZERO ? ST_INIT : ST_IDLE;
      init_ptr <= '0;
      lat_cnt  <= '0;
      rdata_q  <= ZERO_WORD;
      err_q    <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_INIT) init_ptr <= init_ptr + AW'(1);
      if (accept) begin
        lat_cnt <= 2'(READ_LATENCY - 1);
        err_q   <= acc_err;
        rdata_q <= (acc_err || req_we) ? ZERO_WORD : ld_data;
      end else if (state == ST_WAIT) begin
        lat_cnt <= lat_cnt - 2'd1;
      end else if (state == ST_RESP && resp_ready) begin
        rdata_q <= ZERO_WORD;
        err_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl (DEPTH=32, READ_LATENCY=3, INIT_ZERO=1)
// with hand-computed expectations.
module tb_data_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_ram_ctrl #(
    .DEPTH        (32),
    .ADDR_W       (32),
    .READ_LATENCY (3),
    .INIT_ZERO    (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Issue one request, measure acceptance-to-resp_valid cycles, optionally
  // hold off resp_ready for `hold` cycles, then retire the response.
  task automatic do_req(input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold,
                        output logic [31:0] rdata, output logic err,
                        output int lat);
    wait_ready();
    req_valid = 1'b1; req_we = we; req_size = size;
    req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!resp_valid) check("resp_timeout", 32'd0, 32'd1);
    rdata = resp_rdata;
    err   = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_rdata", resp_rdata, rdata);
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("post_resp_ready", {31'd0, req_ready}, 32'd1);
    check("post_resp_valid", {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic count_init(input string tag);
    int cyc = 0;
    logic seen_resp = 1'b0;
    while (!req_ready && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (resp_valid) seen_resp = 1'b1;
    end
    check(tag, cyc, 32'd32);
    check({tag, "_no_resp"}, {31'd0, seen_resp}, 32'd0);
  endtask

  typedef struct {
    string       tag;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    // reset values while rst is held
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    rst = 1'b0;
    count_init("init_cycles");

    vecs = '{
      '{"lw_w5_zero", 0, 2, 0, 32'h14, 32'h0, 32'h00000000, 0, 3},
      '{"sw_10",      1, 2, 0, 32'h10, 32'h8899AABB, 32'h0, 0, 1},
      '{"lb_12",      0, 0, 0, 32'h12, 32'h0, 32'hFFFFFF99, 0, 3},
      '{"lbu_12",     0, 0, 1, 32'h12, 32'h0, 32'h00000099, 0, 3},
      '{"lhu_12",     0, 1, 1, 32'h12, 32'h0, 32'h00008899, 0, 3},
      '{"lh_12",      0, 1, 0, 32'h12, 32'h0, 32'hFFFF8899, 0, 3},
      '{"lb_10",      0, 0, 0, 32'h10, 32'h0, 32'hFFFFFFBB, 0, 3},
      '{"lhu_10",     0, 1, 1, 32'h10, 32'h0, 32'h0000AABB, 0, 3},
      '{"sb_11",      1, 0, 0, 32'h11, 32'hFFFFFF5A, 32'h0, 0, 1},
      '{"lw_merge",   0, 2, 0, 32'h10, 32'h0, 32'h88995ABB, 0, 3},
      '{"sh_16",      1, 1, 0, 32'h16, 32'hABCD1234, 32'h0, 0, 1},
      '{"lw_14",      0, 2, 0, 32'h14, 32'h0, 32'h12340000, 0, 3},
      '{"lw_mis",     0, 2, 0, 32'h02, 32'h0, 32'h0, 1, 1},
      '{"sh_mis",     1, 1, 0, 32'h11, 32'hFFFFFFFF, 32'h0, 1, 1},
      '{"lw_nochg",   0, 2, 0, 32'h10, 32'h0, 32'h88995ABB, 0, 3},
      '{"lw_range",   0, 2, 0, 32'h80, 32'h0, 32'h0, 1, 1},
      '{"sw_range",   1, 2, 0, 32'h80, 32'h11111111, 32'h0, 1, 1},
      '{"rsvd_size",  0, 3, 0, 32'h10, 32'h0, 32'h0, 1, 1},
      '{"lw_0",       0, 2, 0, 32'h00, 32'h0, 32'h00000000, 0, 3}
    };

    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
             vecs[i].wdata, 0, rd, er, lat);
      check({vecs[i].tag, "_rdata"}, rd, vecs[i].exp_rdata);
      check({vecs[i].tag, "_err"}, {31'd0, er}, {31'd0, vecs[i].exp_err});
      check({vecs[i].tag, "_lat"}, lat, vecs[i].exp_lat);
    end

    // backpressure: response held for 4 cycles
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 4, rd, er, lat);
    check("bp_rdata", rd, 32'h88995ABB);
    check("bp_lat", lat, 32'd3);

    // reset while a load sits in WAIT
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2;
    req_unsigned = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("wait_no_valid", {31'd0, resp_valid}, 32'd0);
    check("wait_ready_low", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_wait_valid", {31'd0, resp_valid}, 32'd0);
    count_init("reinit_cycles");
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
    check("reinit_lw10", rd, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0, rd, er, lat);
    check("reinit_lw14", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
